// File: rtl/jt10_mix_if.sv
// Bundle between the mixer and its host: mix request plus channel controls in,
// stereo mix and status flags out.
interface jt10_mix_if #(
   parameter int NCH = 6,
   parameter int W   = 16,
   parameter int OW  = 16
);
   logic                 sample;
   logic [NCH*W-1:0]     ch_data;
   logic [NCH*8-1:0]     ch_gain;
   logic [NCH*2-1:0]     ch_pan;
   logic [NCH-1:0]       ch_enable;
   logic signed [OW-1:0] snd_left;
   logic signed [OW-1:0] snd_right;
   logic                 snd_sample;
   logic                 clip;
   logic                 overrun;

   modport master (
      output sample, ch_data, ch_gain, ch_pan, ch_enable,
      input  snd_left, snd_right, snd_sample, clip, overrun
   );

   modport slave (
      input  sample, ch_data, ch_gain, ch_pan, ch_enable,
      output snd_left, snd_right, snd_sample, clip, overrun
   );
endinterface

// File: rtl/jt10_mix.sv
// Sequential stereo mixer: one channel per cen cycle is scaled by a Q4.4 gain,
// panned into left/right accumulators, then saturated to the output width.
module jt10_mix #(
   parameter int NCH = 6,
   parameter int W   = 16,
   parameter int OW  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   jt10_mix_if.slave  bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int AW = W + 5 + $clog2(NCH);
   localparam logic signed [AW-1:0] ACC_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [NCH*W-1:0]     data_r;
   logic [NCH*8-1:0]     gain_r;
   logic [NCH*2-1:0]     pan_r;
   logic [NCH-1:0]       en_r;
   logic [CW-1:0]        idx_r;
   logic signed [AW-1:0] acc_l_r;
   logic signed [AW-1:0] acc_r_r;
   logic signed [OW-1:0] left_r;
   logic signed [OW-1:0] right_r;
   logic                 snd_sample_r;
   logic                 clip_r;
   logic                 overrun_r;

   logic signed [W-1:0]  cur_data_s;
   logic [7:0]           cur_gain_s;
   logic signed [W+8:0]  prod_s;
   logic signed [AW-1:0] term_s;
   logic                 to_l_s;
   logic                 to_r_s;
   logic                 last_s;

   function automatic logic signed [OW-1:0] saturate(input logic signed [AW-1:0] v);
      if (v > ACC_MAX) begin
         saturate = ACC_MAX[OW-1:0];
      end else if (v < ACC_MIN) begin
         saturate = ACC_MIN[OW-1:0];
      end else begin
         saturate = v[OW-1:0];
      end
   endfunction

   function automatic logic overflows(input logic signed [AW-1:0] v);
      overflows = (v > ACC_MAX) || (v < ACC_MIN);
   endfunction

   // Current channel term: dropping the 4 LSBs of the signed product floors toward -inf.
   always_comb begin
      cur_data_s = data_r[idx_r*W +: W];
      cur_gain_s = gain_r[idx_r*8 +: 8];
      prod_s     = cur_data_s * $signed({1'b0, cur_gain_s});
      term_s     = AW'($signed(prod_s[W+8:4]));
      to_l_s     = en_r[idx_r] & pan_r[idx_r*2 + 1];
      to_r_s     = en_r[idx_r] & pan_r[idx_r*2];
      last_s     = (idx_r == CW'(NCH-1));
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.sample) begin
               state_nxt_s = ACC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACC: begin
            if (last_s) begin
               state_nxt_s = OUT;
            end else begin
               state_nxt_s = ACC;
            end
         end
         OUT:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else if (cen) begin
         state_r <= state_nxt_s;
      end
   end

   // Snapshot, accumulation and output registers; snd_sample self-clears after one clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r       <= '0;
         gain_r       <= '0;
         pan_r        <= '0;
         en_r         <= '0;
         idx_r        <= '0;
         acc_l_r      <= '0;
         acc_r_r      <= '0;
         left_r       <= '0;
         right_r      <= '0;
         snd_sample_r <= 1'b0;
         clip_r       <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         snd_sample_r <= 1'b0;
         if (cen) begin
            if (bus.sample && (state_r != IDLE)) begin
               overrun_r <= 1'b1;
            end
            case (state_r)
               IDLE: begin
                  if (bus.sample) begin
                     data_r  <= bus.ch_data;
                     gain_r  <= bus.ch_gain;
                     pan_r   <= bus.ch_pan;
                     en_r    <= bus.ch_enable;
                     idx_r   <= '0;
                     acc_l_r <= '0;
                     acc_r_r <= '0;
                  end
               end
               ACC: begin
                  if (to_l_s) begin
                     acc_l_r <= acc_l_r + term_s;
                  end
                  if (to_r_s) begin
                     acc_r_r <= acc_r_r + term_s;
                  end
                  if (last_s) begin
                     idx_r <= '0;
                  end else begin
                     idx_r <= idx_r + CW'(1);
                  end
               end
               OUT: begin
                  left_r       <= saturate(acc_l_r);
                  right_r      <= saturate(acc_r_r);
                  clip_r       <= overflows(acc_l_r) | overflows(acc_r_r);
                  snd_sample_r <= 1'b1;
               end
               default: begin
                  idx_r <= '0;
               end
            endcase
         end
      end
   end

   assign bus.snd_left   = left_r;
   assign bus.snd_right  = right_r;
   assign bus.snd_sample = snd_sample_r;
   assign bus.clip       = clip_r;
   assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_jt10_mix.sv
// Bench for jt10_mix: table of mix vectors plus a scoreboard queue checked on each
// snd_sample pulse, and hand sequences for latency, overrun and mid-mix reset.
module tb_jt10_mix;
   localparam int NCH = 6;
   localparam int W   = 16;
   localparam int OW  = 16;

   typedef struct packed {
      logic [5:0][15:0] d;
      logic [5:0][7:0]  g;
      logic [5:0][1:0]  p;
      logic [5:0]       en;
   } stim_t;

   typedef struct packed {
      logic signed [15:0] l;
      logic signed [15:0] r;
      logic               c;
   } res_t;

   typedef struct packed {
      stim_t s;
      res_t  e;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic cen;
   vec_t vecs [11];
   res_t sbq [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulses = 0;

   jt10_mix_if #(.NCH(NCH), .W(W), .OW(OW)) bus ();

   jt10_mix #(.NCH(NCH), .W(W), .OW(OW)) dut (
      .clk (clk),
      .rst (rst),
      .cen (cen),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] sat16(input longint v);
      if (v > 32767) return 16'h7FFF;
      else if (v < -32768) return 16'h8000;
      else return 16'(v);
   endfunction

   function automatic res_t model(input stim_t s);
      longint l, r, pr;
      res_t   o;
      l = 0;
      r = 0;
      for (int i = 0; i < NCH; i++) begin
         pr = (longint'($signed(s.d[i])) * longint'(s.g[i])) >>> 4;
         if (s.en[i] && s.p[i][1]) l += pr;
         if (s.en[i] && s.p[i][0]) r += pr;
      end
      o.l = sat16(l);
      o.r = sat16(r);
      o.c = (l > 32767) || (l < -32768) || (r > 32767) || (r < -32768);
      return o;
   endfunction

   // Scoreboard: every snd_sample pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!rst && bus.snd_sample === 1'b1) begin
         res_t e;
         pulses++;
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: got snd_sample=1, expected no pulse");
         end else begin
            e = sbq.pop_front();
            check("mix_left",  $signed(bus.snd_left),  $signed(e.l));
            check("mix_right", $signed(bus.snd_right), $signed(e.r));
            check("mix_clip",  bus.clip, e.c);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input logic c);
      cen = c;
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input stim_t s);
      bus.ch_data   = s.d;
      bus.ch_gain   = s.g;
      bus.ch_pan    = s.p;
      bus.ch_enable = s.en;
   endtask

   task automatic scramble();
      bus.ch_data   = {$urandom(), $urandom(), $urandom()};
      bus.ch_gain   = 48'({$urandom(), $urandom()});
      bus.ch_pan    = 12'($urandom());
      bus.ch_enable = 6'($urandom());
   endtask

   task automatic wait_done(input string name);
      int b;
      b = 0;
      while (sbq.size() != 0 && b < 200) begin
         step($urandom_range(0, 3) != 0);
         b++;
      end
      if (sbq.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got no snd_sample in 200 clks, expected one", name);
         sbq.delete();
      end
   endtask

   task automatic run_mix(input vec_t v, input string name);
      apply(v.s);
      bus.sample = 1'b1;
      step(1'b1);
      sbq.push_back(v.e);
      bus.sample = 1'b0;
      scramble();
      wait_done(name);
   endtask

   initial begin
      vec_t  v;
      int    p0;
      logic signed [15:0] held;

      for (int i = 0; i < 11; i++) vecs[i] = '0;
      vecs[0].s.d[0] = 16'sd1000; vecs[0].s.g[0] = 8'h10; vecs[0].s.p[0] = 2'b11;
      vecs[0].s.en = 6'b000001; vecs[0].e.l = 16'sd1000; vecs[0].e.r = 16'sd1000; vecs[0].e.c = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         vecs[1].s.d[k] = 16'h7FFF; vecs[1].s.g[k] = 8'hFF; vecs[1].s.p[k] = 2'b11;
         vecs[2].s.d[k] = 16'h8000; vecs[2].s.g[k] = 8'hFF; vecs[2].s.p[k] = 2'b11;
      end
      vecs[1].s.en = 6'b111111; vecs[1].e.l = 16'sd32767; vecs[1].e.r = 16'sd32767; vecs[1].e.c = 1'b1;
      vecs[2].s.en = 6'b111111; vecs[2].e.l = 16'h8000; vecs[2].e.r = 16'h8000; vecs[2].e.c = 1'b1;
      vecs[3].s.d[0] = 16'hFFFF; vecs[3].s.g[0] = 8'h08; vecs[3].s.p[0] = 2'b11;
      vecs[3].s.en = 6'b000001; vecs[3].e.l = -16'sd1; vecs[3].e.r = -16'sd1; vecs[3].e.c = 1'b0;
      vecs[4].s.d[0] = 16'sd500; vecs[4].s.g[0] = 8'h10; vecs[4].s.p[0] = 2'b10;
      vecs[4].s.d[1] = -16'sd300; vecs[4].s.g[1] = 8'h10; vecs[4].s.p[1] = 2'b01;
      vecs[4].s.en = 6'b000011; vecs[4].e.l = 16'sd500; vecs[4].e.r = -16'sd300; vecs[4].e.c = 1'b0;
      vecs[5].s.d[0] = 16'sd1000; vecs[5].s.g[0] = 8'h10; vecs[5].s.p[0] = 2'b11;
      vecs[5].s.d[2] = 16'sd100; vecs[5].s.g[2] = 8'h20; vecs[5].s.p[2] = 2'b11;
      vecs[5].s.en = 6'b000100; vecs[5].e.l = 16'sd200; vecs[5].e.r = 16'sd200; vecs[5].e.c = 1'b0;
      vecs[6].s.d[3] = 16'sd1234; vecs[6].s.g[3] = 8'h10; vecs[6].s.p[3] = 2'b00;
      vecs[6].s.en = 6'b001000; vecs[6].e.l = 16'sd0; vecs[6].e.r = 16'sd0; vecs[6].e.c = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vecs[7].s.d[k] = 16'sd20000; vecs[7].s.g[k] = 8'h10; vecs[7].s.p[k] = 2'b10;
      end
      vecs[7].s.en = 6'b000111; vecs[7].e.l = 16'sd32767; vecs[7].e.r = 16'sd0; vecs[7].e.c = 1'b1;
      vecs[8].s.d[4] = -16'sd7; vecs[8].s.g[4] = 8'h03; vecs[8].s.p[4] = 2'b01;
      vecs[8].s.d[5] = 16'sd7; vecs[8].s.g[5] = 8'h03; vecs[8].s.p[5] = 2'b10;
      vecs[8].s.en = 6'b110000; vecs[8].e.l = 16'sd1; vecs[8].e.r = -16'sd2; vecs[8].e.c = 1'b0;
      vecs[9].s.d[0] = 16'sd32767; vecs[9].s.g[0] = 8'h10; vecs[9].s.p[0] = 2'b11;
      vecs[9].s.en = 6'b000001; vecs[9].e.l = 16'sd32767; vecs[9].e.r = 16'sd32767; vecs[9].e.c = 1'b0;
      vecs[10].s.d[0] = 16'h8000; vecs[10].s.g[0] = 8'h10; vecs[10].s.p[0] = 2'b11;
      vecs[10].s.d[1] = 16'hFFFF; vecs[10].s.g[1] = 8'h10; vecs[10].s.p[1] = 2'b01;
      vecs[10].s.en = 6'b000011; vecs[10].e.l = 16'h8000; vecs[10].e.r = 16'h8000; vecs[10].e.c = 1'b1;

      rst = 1'b1;
      cen = 1'b0;
      bus.sample = 1'b0;
      apply('0);
      step(1'b0);
      step(1'b1);
      check("rst_left", $signed(bus.snd_left), 0);
      check("rst_right", $signed(bus.snd_right), 0);
      check("rst_flags", {bus.snd_sample, bus.clip, bus.overrun}, 0);
      rst = 1'b0;
      step(1'b1);

      // Exact latency with a cen stall inside ACC.
      apply(vecs[0].s);
      bus.sample = 1'b1;
      step(1'b1);
      sbq.push_back(vecs[0].e);
      bus.sample = 1'b0;
      scramble();
      for (int c = 1; c <= 6; c++) begin
         step(1'b1);
         if (c == 3) begin
            for (int s = 0; s < 4; s++) step(1'b0);
            check("stall_no_pulse", bus.snd_sample, 0);
         end
      end
      check("latency_early", bus.snd_sample, 0);
      step(1'b1);
      check("latency_pulse", bus.snd_sample, 1);
      step(1'b0);
      check("pulse_width", bus.snd_sample, 0);
      wait_done("latency");

      for (int i = 0; i < 11; i++) run_mix(vecs[i], "table");

      for (int i = 0; i < 4; i++) begin
         v.s.d  = {$urandom(), $urandom(), $urandom()};
         v.s.g  = 48'({$urandom(), $urandom()});
         v.s.p  = 12'($urandom());
         v.s.en = 6'($urandom());
         v.e    = model(v.s);
         run_mix(v, "random");
      end

      run_mix(vecs[4], "pre_hold");
      held = bus.snd_left;
      for (int i = 0; i < 6; i++) begin
         scramble();
         step($urandom_range(0, 1) != 0);
      end
      check("hold_left", $signed(bus.snd_left), $signed(held));

      // Strobe during ACC is ignored, sets overrun, and the cycle-0 snapshot wins.
      check("overrun_clear", bus.overrun, 0);
      apply(vecs[0].s);
      bus.sample = 1'b1;
      step(1'b1);
      sbq.push_back(vecs[0].e);
      bus.sample = 1'b0;
      p0 = pulses;
      step(1'b1);
      step(1'b1);
      bus.ch_data[15:0] = 16'sd5000;
      bus.sample = 1'b1;
      step(1'b1);
      bus.sample = 1'b0;
      check("overrun_set", bus.overrun, 1);
      wait_done("overrun");
      for (int i = 0; i < 15; i++) step(1'b1);
      check("single_pulse", pulses - p0, 1);
      check("overrun_sticky", bus.overrun, 1);

      // Asynchronous reset on cen cycle 4 of a mix.
      apply(vecs[9].s);
      bus.sample = 1'b1;
      step(1'b1);
      sbq.push_back(vecs[9].e);
      bus.sample = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1);
      cen = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("abort_left", $signed(bus.snd_left), 0);
      check("abort_right", $signed(bus.snd_right), 0);
      check("abort_flags", {bus.snd_sample, bus.clip, bus.overrun}, 0);
      sbq.delete();
      p0 = pulses;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) step(1'b1);
      check("abort_no_pulse", pulses - p0, 0);
      run_mix(vecs[4], "after_reset");
      check("after_reset_pulse", pulses - p0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/jt10_mix.md
JT10_MIX -- requirements
Module: jt10_mix

Interface
REQ-001 SHALL have parameter NCH, default 6, meaning number of input channels (legal range 1..16).
REQ-002 SHALL have parameter W, default 16, meaning signed input sample width per channel.
REQ-003 SHALL have parameter OW, default 16, meaning signed output sample width (OW <= W+4).
REQ-004 SHALL have port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have port cen  input  1  meaning clock enable; state advances only on clk edges with cen=1.
REQ-007 SHALL have port sample  input  1  meaning mix-request strobe, sampled on cen cycles.
REQ-008 SHALL have port ch_data  input  NCH*W  meaning signed samples, channel i at bits [i*W +: W].
REQ-009 SHALL have port ch_gain  input  NCH*8  meaning unsigned Q4.4 gain, channel i at [i*8 +: 8].
REQ-010 SHALL have port ch_pan  input  NCH*2  meaning bit 2i+1 routes channel i left, bit 2i routes it right.
REQ-011 SHALL have port ch_enable  input  NCH  meaning per-channel enable mask.
REQ-012 SHALL have port snd_left  output  OW  meaning signed left mix.
REQ-013 SHALL have port snd_right  output  OW  meaning signed right mix.
REQ-014 SHALL have port snd_sample  output  1  meaning one-clk pulse when new outputs are valid.
REQ-015 SHALL have port clip  output  1  meaning either side saturated in the current output sample.
REQ-016 SHALL have port overrun  output  1  meaning sticky flag: a strobe arrived while busy.

Function
REQ-017 SHALL implement states IDLE, ACC, OUT; transitions only on cen cycles.
REQ-018 IDLE with sample=1 SHALL snapshot ch_data, ch_gain, ch_pan and ch_enable, clear both accumulators, load channel index 0, and enter ACC.
REQ-019 ACC SHALL process exactly one channel per cen cycle, index 0 to NCH-1, using snapshot values only.
REQ-020 Per channel: product = data (signed W) x gain (zero-extended, signed 9 bits), arithmetic right shift by 4 (floor toward -inf).
REQ-021 Product SHALL be added to the left accumulator if enabled and pan left bit set, and to the right accumulator if enabled and pan right bit set; otherwise accumulators hold.
REQ-022 Accumulators SHALL be W+5+clog2(NCH) bits signed; no internal overflow is possible.
REQ-023 After channel NCH-1, state SHALL go to OUT; in OUT each accumulator is saturated to [-2^(OW-1), 2^(OW-1)-1] and registered to snd_left/snd_right.
REQ-024 clip SHALL be registered in OUT as 1 if either side saturated, else 0; it holds until the next OUT.
REQ-025 snd_sample SHALL be 1 for exactly one clk, the clk edge following the OUT cen cycle, then 0; state returns to IDLE.
REQ-026 Latency: strobe accepted on cen cycle 0; channels on cen cycles 1..NCH; outputs and snd_sample update on cen cycle NCH+1.
REQ-027 sample=1 in ACC or OUT SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-028 Input changes after the snapshot SHALL NOT affect the result in progress.
REQ-029 With cen=0 all state, counters and outputs SHALL hold; snd_sample SHALL stay 0.
REQ-030 snd_left/snd_right SHALL hold their last value between OUT cycles.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, index 0, accumulators 0, snapshots 0, snd_left=0, snd_right=0, snd_sample=0, clip=0, overrun=0.
REQ-032 Reset during ACC or OUT SHALL abort the mix with no snd_sample pulse; the first strobe after release SHALL be accepted normally.

Verification
REQ-033 NCH=6; ch0=1000, gain 0x10, pan 11, others disabled; strobe -> snd_left=snd_right=1000, clip=0, snd_sample on cen cycle 7.
REQ-034 All 6 channels 32767, gain 0xFF, pan 11, enabled -> snd_left=snd_right=32767, clip=1; repeat with -32768 -> both -32768, clip=1.
REQ-035 ch0=-1, gain 0x08, pan 11, others disabled -> snd_left=snd_right=-1, from floor rounding of -8>>4.
REQ-036 ch0=500 pan 10, ch1=-300 pan 01, both gain 0x10 -> snd_left=500, snd_right=-300.
REQ-037 Strobe on cen cycle 0, change ch0 and strobe again on cen cycle 3 -> one snd_sample only, result from cycle-0 snapshot, overrun=1.
REQ-038 Assert rst on cen cycle 4 of a mix -> all outputs 0 immediately, no snd_sample; a new strobe after release yields the correct mix.
